// File: rtl/iq_sample_ingest.sv
// I/Q sample ingest: captures the packed I/Q bus on a divided sample tick into a
// small first-word-fall-through FIFO and presents it as a valid/ready stream.
module iq_sample_ingest #(
  parameter int BITS       = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*BITS-1:0] iq_in,
  output logic [BITS-1:0]   out_i,
  output logic [BITS-1:0]   out_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  localparam logic [15:0]      TCNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  logic [15:0]       tcnt_q, tcnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [2*BITS-1:0] mem_q [FIFO_DEPTH];

  logic tick, full, empty, pop, wr_en, drop;
  logic [2*BITS-1:0] head;
  logic [BITS-1:0]   col [2];

  assign tick  = en && (tcnt_q == TCNT_LAST);
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign pop   = !empty && out_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en = tick && (!full || pop);
  assign drop  = tick && full && !pop;

  always_comb begin
    tcnt_d = tcnt_q;
    if (en) begin
      tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;
    end

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= iq_in;
    end
  end

  assign head = mem_q[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_col
      assign col[gi] = empty ? '0 : head[gi*BITS +: BITS];
    end
  endgenerate

  assign out_i     = col[0];
  assign out_q     = col[1];
  assign out_valid = !empty;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_iq_sample_ingest.sv
// Directed bench for iq_sample_ingest (BITS=16, CLK_DIV=4, FIFO_DEPTH=8).
module tb_iq_sample_ingest;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] iq_in;
  logic [15:0] out_i, out_q;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  iq_sample_ingest #(.BITS(16), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .iq_in     (iq_in),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // One sample period starting from tcnt=0: the tick lands on the 4th edge.
  task automatic fill_period(int ival);
    iq_in = {16'hA000 | 16'(ival), 16'(ival)};
    step(4);
  endtask

  task automatic drain_expect(int first, int n, string tag);
    for (int j = 0; j < n; j++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_i"}, 32'(out_i), 32'(first + j));
      chk({tag, "_q"}, 32'(out_q), 32'(16'hA000 | 16'(first + j)));
      step(1);
    end
    chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_end_i"}, 32'(out_i), 32'd0);
    chk({tag, "_end_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; iq_in = 32'h1234_5678;
    step(2);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_i", 32'(out_i), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Streaming with a ready consumer: one beat every 4 cycles, level <= 1.
    rst = 1'b0; en = 1'b1; out_ready = 1'b1; iq_in = {16'h8000, 16'h7FFF};
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk($sformatf("stream_valid_c%0d", k), 32'(out_valid), 32'((k % 4) == 0));
      chk($sformatf("stream_level_c%0d", k), 32'(level), 32'((k % 4) == 0));
      if ((k % 4) == 0) begin
        chk($sformatf("stream_i_c%0d", k), 32'(out_i), 32'h7FFF);
        chk($sformatf("stream_q_c%0d", k), 32'(out_q), 32'h8000);
      end
    end

    // Stall for 8 ticks: FIFO fills exactly, then drains in order.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) fill_period(k);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd0);
    en = 1'b0; out_ready = 1'b1;
    drain_expect(0, 8, "drain8");

    // Stall for 18 ticks: the 9th tick is the first drop.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      fill_period(k);
      if (k == 7) chk("ovf_before_9th", 32'(overflow), 32'd0);
      if (k == 8) begin
        chk("ovf_after_9th", 32'(overflow), 32'd1);
        chk("level_after_9th", 32'(level), 32'd8);
      end
    end
    chk("ovf_level_end", 32'(level), 32'd8);
    en = 1'b0; out_ready = 1'b1;
    drain_expect(0, 8, "drain_ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the tick edge: push and pop both happen.
    do_reset();
    chk("reset_clears_ovf", 32'(overflow), 32'd0);
    en = 1'b1;
    for (int k = 0; k < 8; k++) fill_period(k);
    iq_in = {16'hA008, 16'h0008};
    step(3);
    chk("full_pre_tick_level", 32'(level), 32'd8);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("full_pop_level", 32'(level), 32'd8);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(out_i), 32'd1);
    en = 1'b0; out_ready = 1'b1;
    drain_expect(1, 8, "drain_full_pop");

    // en low for 3 cycles at tcnt=2 delays the tick by 3; draining continues.
    do_reset();
    en = 1'b1; iq_in = {16'h0011, 16'h0011};
    step(4);
    chk("pause_first_valid", 32'(out_valid), 32'd1);
    step(2);
    en = 1'b0; out_ready = 1'b1; iq_in = {16'h0022, 16'h0022};
    step(1);
    chk("pause_drained", 32'(out_valid), 32'd0);
    step(2);
    chk("pause_no_capture", 32'(out_valid), 32'd0);
    en = 1'b1;
    step(1);
    chk("pause_no_early_tick", 32'(out_valid), 32'd0);
    step(1);
    chk("pause_delayed_tick", 32'(out_valid), 32'd1);
    chk("pause_delayed_i", 32'(out_i), 32'h0022);

    // Reset mid-stream with level=5 and tcnt=3.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 5; k++) fill_period(k);
    step(3);
    chk("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    step(1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_i", 32'(out_i), 32'd0);
    chk("mid_rst_q", 32'(out_q), 32'd0);
    rst = 1'b0; iq_in = {16'h0055, 16'h0066};
    step(3);
    chk("post_rst_no_tick", 32'(out_valid), 32'd0);
    step(1);
    chk("post_rst_tick", 32'(out_valid), 32'd1);
    chk("post_rst_i", 32'(out_i), 32'h0066);
    chk("post_rst_q", 32'(out_q), 32'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_sample_ingest.md
# iq_sample_ingest

Synthesizable input stage that converts the packed two-column I/Q sample bus produced by the waveform source into a handshaked sample stream for the GMSK demodulator. It captures the bus on a programmable clock-divided sample tick and buffers samples in a small first-word-fall-through FIFO. It presents them on a valid/ready interface and flags samples lost to back-pressure.

## Interface
- BITS, 16, width of one sample column (I or Q), two's complement
- CLK_DIV, 4, clock cycles per sample tick; legal range 2..65535
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  enables tick counter and capture
- iq_in  input  2*BITS  packed sample; bits [BITS-1:0] = I (column 0), [2*BITS-1:BITS] = Q (column 1)
- out_i  output  BITS  I of FIFO head; 0 when empty
- out_q  output  BITS  Q of FIFO head; 0 when empty
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: at least one sample dropped since reset

## Operation
- Tick counter tcnt, 16 bits, counts 0..CLK_DIV-1 while en=1; wraps to 0 after CLK_DIV-1; held (not cleared) while en=0.
- Tick = en && tcnt==CLK_DIV-1. First tick occurs CLK_DIV cycles after en first goes high following reset.
- On a tick, iq_in is sampled at that clock edge and becomes a push request.
- Pop = out_valid && out_ready.
- Push, FIFO not full: write at wr_ptr, increment wr_ptr.
- Push, FIFO full, no pop: sample dropped, FIFO unchanged, overflow set to 1.
- Push and pop in the same cycle: both occur, including at full (no drop) and at empty with pop impossible (out_valid=0, so push only).
- level = entries after update; increments on push only, decrements on pop only, unchanged on push+pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; full/empty derive from level.
- overflow clears only on rst.
- en=0 stops captures only; draining via out_ready continues.
- No arithmetic on sample data: I and Q pass bit-exact.

## Timing
- Reset (rst high at an edge): tcnt=0, pointers=0, level=0, out_valid=0, out_i=out_q=0, overflow=0. Reset wins over any simultaneous push/pop. Reset mid-stream discards buffered samples.
- Capture latency: sample taken at tick edge N appears on out_i/out_q with out_valid=1 after edge N when the FIFO was empty (1 cycle).
- Head update: after a pop at edge N, the next entry (or 0 with out_valid=0) is presented after edge N.
- Throughput: 1 sample per CLK_DIV cycles; consumer may stall arbitrarily; FIFO absorbs up to FIFO_DEPTH samples.
- All outputs registered or derived from registered state only; no combinational path from out_ready to out_valid/out_i/out_q.

## Test plan
- Reset then en=1, CLK_DIV=4, out_ready=1, iq_in={Q=16'h8000, I=16'h7FFF}: first out_valid pulse 4 cycles after en, out_i=16'h7FFF, out_q=16'h8000, one beat every 4 cycles, level never exceeds 1.
- Ramp I=0,1,2,… per tick with out_ready=0 for 8 ticks (FIFO_DEPTH=8): level=8, overflow=0; then out_ready=1 drains 0..7 in order, one per cycle, then out_valid=0, out_i=0.
- Continue stall for 10 ticks with FIFO full: overflow=1 after the 9th tick, level stays 8, drained data is 0..7 (later samples lost); overflow stays 1 after draining.
- Full FIFO, out_ready=1 exactly on a tick cycle: no drop, level stays 8, overflow stays 0, new sample appears last in order.
- en toggled low for 3 cycles mid-period at tcnt=2: tick delayed exactly 3 cycles, no capture while low, draining continues.
- Assert rst with level=5 and tcnt=3: next cycle level=0, out_valid=0, overflow=0, out_i=out_q=0; next tick CLK_DIV cycles after rst release with en=1.
